// File: rtl/bus_arbiter.sv
// Two-master (core m0, DMA m1) to single memory port arbiter with a BUSY timeout.
// Define BUS_ARBITER_RR_EN for round-robin tie-breaking; otherwise m0 wins ties.
module bus_arbiter (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wd_i,
  input  logic [3:0]  m0_be_i,
  output logic [31:0] m0_rd_o,
  output logic        m0_ready_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wd_i,
  input  logic [3:0]  m1_be_i,
  output logic [31:0] m1_rd_o,
  output logic        m1_ready_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  output logic [3:0]  mem_be_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i,
  output logic        err_o
);

  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;

  state_t      r_state;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wd;
  logic [3:0]  r_be;
  logic [7:0]  r_cnt;

  logic w_busy;
  logic w_done;
  logic w_grant1;

  assign w_busy = (r_state != IDLE);
  assign w_done = w_busy && (mem_ready_i || (r_cnt == 8'hFF));

`ifdef BUS_ARBITER_RR_EN
  logic r_last_grant;
  // On a tie the requester that did not win last time gets the bus.
  assign w_grant1 = m1_req_i && (!m0_req_i || !r_last_grant);
`else
  assign w_grant1 = m1_req_i && !m0_req_i;
`endif

  // r_cnt holds the 1-based index of the current BUSY cycle, so 255 marks BUSY cycle 255.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wd    <= '0;
      r_be    <= '0;
      r_cnt   <= '0;
`ifdef BUS_ARBITER_RR_EN
      r_last_grant <= 1'b1;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (m0_req_i || m1_req_i) begin
            r_state <= w_grant1 ? BUSY1 : BUSY0;
            r_we    <= w_grant1 ? m1_we_i   : m0_we_i;
            r_addr  <= w_grant1 ? m1_addr_i : m0_addr_i;
            r_wd    <= w_grant1 ? m1_wd_i   : m0_wd_i;
            r_be    <= w_grant1 ? m1_be_i   : m0_be_i;
            r_cnt   <= 8'd1;
`ifdef BUS_ARBITER_RR_EN
            r_last_grant <= w_grant1;
`endif
          end
        end
        default: begin
          if (w_done) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
      endcase
    end
  end

  assign mem_req_o  = w_busy;
  assign mem_we_o   = r_we;
  assign mem_addr_o = r_addr;
  assign mem_wd_o   = r_wd;
  assign mem_be_o   = r_be;

  // Completion (or timeout) is reported combinationally in the cycle it happens.
  assign m0_ready_o = (r_state == BUSY0) && w_done;
  assign m1_ready_o = (r_state == BUSY1) && w_done;
  assign m0_rd_o    = ((r_state == BUSY0) && mem_ready_i) ? mem_rd_i : 32'h0;
  assign m1_rd_o    = ((r_state == BUSY1) && mem_ready_i) ? mem_rd_i : 32'h0;
  assign err_o      = w_busy && (r_cnt == 8'hFF) && !mem_ready_i;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with a transaction-level reference model.
module tb_bus_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        m0_req_i = 1'b0, m0_we_i = 1'b0;
  logic [31:0] m0_addr_i = '0, m0_wd_i = '0;
  logic [3:0]  m0_be_i = '0;
  logic [31:0] m0_rd_o;
  logic        m0_ready_o;
  logic        m1_req_i = 1'b0, m1_we_i = 1'b0;
  logic [31:0] m1_addr_i = '0, m1_wd_i = '0;
  logic [3:0]  m1_be_i = '0;
  logic [31:0] m1_rd_o;
  logic        m1_ready_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wd_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_rd_i = '0;
  logic        mem_ready_i = 1'b0;
  logic        err_o;

  bus_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i), .m0_wd_i(m0_wd_i),
    .m0_be_i(m0_be_i), .m0_rd_o(m0_rd_o), .m0_ready_o(m0_ready_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_wd_i(m1_wd_i),
    .m1_be_i(m1_be_i), .m1_rd_o(m1_rd_o), .m1_ready_o(m1_ready_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wd_o(mem_wd_o), .mem_be_o(mem_be_o), .mem_rd_i(mem_rd_i),
    .mem_ready_i(mem_ready_i), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Reference model: which master owns the bus and how many BUSY cycles it has used.
  int          owner = -1;
  int          cyc = 0;
  int          win = 0;
  logic        m_we = 1'b0;
  logic [31:0] m_addr = '0, m_wd = '0;
  logic [3:0]  m_be = '0;
`ifdef BUS_ARBITER_RR_EN
  int          last = 1;
`endif

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      owner = -1;
      cyc = 0;
`ifdef BUS_ARBITER_RR_EN
      last = 1;
`endif
    end else if (owner < 0) begin
      if (m0_req_i || m1_req_i) begin
`ifdef BUS_ARBITER_RR_EN
        if (m0_req_i && m1_req_i) win = 1 - last;
        else win = m0_req_i ? 0 : 1;
        last = win;
`else
        win = m0_req_i ? 0 : 1;
`endif
        owner = win;
        cyc = 1;
        m_we   = win ? m1_we_i   : m0_we_i;
        m_addr = win ? m1_addr_i : m0_addr_i;
        m_wd   = win ? m1_wd_i   : m0_wd_i;
        m_be   = win ? m1_be_i   : m0_be_i;
      end
    end else if (mem_ready_i || cyc == 255) begin
      owner = -1;
    end else begin
      cyc++;
    end
  end

  logic        e_done;
  logic [31:0] e_rd;

  always @(negedge clk_i) begin
    if (!rst_i) begin
      e_done = (owner >= 0) && (mem_ready_i || cyc == 255);
      e_rd   = mem_ready_i ? mem_rd_i : 32'h0;
      chk("mdl_mem_req", {31'b0, mem_req_o}, {31'b0, owner >= 0});
      chk("mdl_m0_ready", {31'b0, m0_ready_o}, {31'b0, e_done && owner == 0});
      chk("mdl_m1_ready", {31'b0, m1_ready_o}, {31'b0, e_done && owner == 1});
      chk("mdl_m0_rd", m0_rd_o, (owner == 0) ? e_rd : 32'h0);
      chk("mdl_m1_rd", m1_rd_o, (owner == 1) ? e_rd : 32'h0);
      chk("mdl_err", {31'b0, err_o}, {31'b0, (owner >= 0) && cyc == 255 && !mem_ready_i});
      if (owner >= 0) begin
        chk("mdl_mem_we", {31'b0, mem_we_o}, {31'b0, m_we});
        chk("mdl_mem_addr", mem_addr_o, m_addr);
        chk("mdl_mem_wd", mem_wd_o, m_wd);
        chk("mdl_mem_be", {28'b0, mem_be_o}, {28'b0, m_be});
      end
    end
  end

  int          n;
  int          errs;
  logic [31:0] g [4];

  initial begin
    // Reset state while rst_i is held, before any clock edge
    #2;
    chk("rst_mem_req", {31'b0, mem_req_o}, 32'h0);
    chk("rst_m0_ready", {31'b0, m0_ready_o}, 32'h0);
    chk("rst_m1_ready", {31'b0, m1_ready_o}, 32'h0);
    chk("rst_err", {31'b0, err_o}, 32'h0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    chk("rst_m0_rd", m0_rd_o, 32'h0);
    tick(); tick();
    rst_i = 1'b0;

    // Single read, ready in BUSY cycle 3
    m0_req_i = 1'b1; m0_addr_i = 32'h100; m0_we_i = 1'b0; m0_be_i = 4'hF;
    tick();
    @(negedge clk_i);
    chk("t1_mem_req_c1", {31'b0, mem_req_o}, 32'h1);
    chk("t1_mem_addr", mem_addr_o, 32'h100);
    chk("t1_ready_c1", {31'b0, m0_ready_o}, 32'h0);
    tick();
    @(negedge clk_i);
    chk("t1_ready_c2", {31'b0, m0_ready_o}, 32'h0);
    tick();
    mem_ready_i = 1'b1; mem_rd_i = 32'hDEADBEEF;
    @(negedge clk_i);
    chk("t1_ready_c3", {31'b0, m0_ready_o}, 32'h1);
    chk("t1_rd_c3", m0_rd_o, 32'hDEADBEEF);
    chk("t1_we", {31'b0, mem_we_o}, 32'h0);
    tick();
    m0_req_i = 1'b0; mem_rd_i = 32'h0BADF00D;
    @(negedge clk_i);
    chk("t1_idle_ready", {31'b0, m0_ready_o}, 32'h0);
    chk("t1_idle_rd", m0_rd_o, 32'h0);
    chk("t1_idle_mem_req", {31'b0, mem_req_o}, 32'h0);
    tick();
    mem_ready_i = 1'b0; mem_rd_i = 32'h0;

    // Continuous tie with memory always ready
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    m0_req_i = 1'b1; m0_addr_i = 32'h10;
    m1_req_i = 1'b1; m1_addr_i = 32'h20; m1_we_i = 1'b0; m1_be_i = 4'hF;
    mem_ready_i = 1'b1; mem_rd_i = 32'h11110000;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      @(negedge clk_i);
      if (mem_req_o) begin
        if (n < 4) g[n] = mem_addr_o;
        n++;
      end
    end
    #1;
    m0_req_i = 1'b0; m1_req_i = 1'b0;
    chk("t2_transfers", n, 32'd4);
`ifdef BUS_ARBITER_RR_EN
    chk("t2_grant0", g[0], 32'h10);
    chk("t2_grant1", g[1], 32'h20);
    chk("t2_grant2", g[2], 32'h10);
    chk("t2_grant3", g[3], 32'h20);
`else
    chk("t2_grant0", g[0], 32'h10);
    chk("t2_grant1", g[1], 32'h10);
    chk("t2_grant2", g[2], 32'h10);
    chk("t2_grant3", g[3], 32'h10);
`endif
    tick();
    mem_ready_i = 1'b0; mem_rd_i = 32'h0;

    // Timeout on an m1 write
    m1_req_i = 1'b1; m1_we_i = 1'b1; m1_addr_i = 32'h2000; m1_wd_i = 32'h12345678; m1_be_i = 4'b0011;
    errs = 0;
    tick();
    for (int k = 1; k <= 255; k++) begin
      @(negedge clk_i);
      if (err_o) errs++;
      if (k == 255) begin
        chk("t3_err", {31'b0, err_o}, 32'h1);
        chk("t3_m1_ready", {31'b0, m1_ready_o}, 32'h1);
        chk("t3_m1_rd", m1_rd_o, 32'h0);
        chk("t3_mem_be", {28'b0, mem_be_o}, 32'h3);
        chk("t3_mem_wd", mem_wd_o, 32'h12345678);
        chk("t3_mem_addr", mem_addr_o, 32'h2000);
      end
      tick();
    end
    m1_req_i = 1'b0; m1_we_i = 1'b0;
    @(negedge clk_i);
    chk("t3_mem_req_after", {31'b0, mem_req_o}, 32'h0);
    chk("t3_err_pulses", errs, 32'd1);
    tick();

    // Memory ready arrives exactly in BUSY cycle 255
    m0_req_i = 1'b1; m0_we_i = 1'b0; m0_addr_i = 32'h3000;
    errs = 0;
    tick();
    for (int k = 1; k <= 255; k++) begin
      if (k == 255) begin
        mem_ready_i = 1'b1; mem_rd_i = 32'hCAFEF00D;
      end
      @(negedge clk_i);
      if (err_o) errs++;
      if (k == 255) begin
        chk("t4_m0_ready", {31'b0, m0_ready_o}, 32'h1);
        chk("t4_m0_rd", m0_rd_o, 32'hCAFEF00D);
      end
      tick();
    end
    m0_req_i = 1'b0; mem_ready_i = 1'b0; mem_rd_i = 32'h0;
    chk("t4_err_pulses", errs, 32'd0);
    @(negedge clk_i);
    chk("t4_mem_req_after", {31'b0, mem_req_o}, 32'h0);
    tick();

    // Asynchronous reset in the middle of a write
    m0_req_i = 1'b1; m0_we_i = 1'b1; m0_addr_i = 32'h4000; m0_wd_i = 32'hA5A5A5A5; m0_be_i = 4'hF;
    tick();
    tick();
    #3;
    rst_i = 1'b1; mem_ready_i = 1'b1; mem_rd_i = 32'h77777777;
    #1;
    chk("t5_mem_req", {31'b0, mem_req_o}, 32'h0);
    chk("t5_mem_we", {31'b0, mem_we_o}, 32'h0);
    chk("t5_mem_addr", mem_addr_o, 32'h0);
    chk("t5_mem_wd", mem_wd_o, 32'h0);
    chk("t5_mem_be", {28'b0, mem_be_o}, 32'h0);
    chk("t5_m0_ready", {31'b0, m0_ready_o}, 32'h0);
    chk("t5_m0_rd", m0_rd_o, 32'h0);
    chk("t5_err", {31'b0, err_o}, 32'h0);
    tick();
    rst_i = 1'b0; m0_we_i = 1'b0; m0_addr_i = 32'h300; mem_rd_i = 32'h55AA55AA;
    tick();
    @(negedge clk_i);
    chk("t5_after_ready", {31'b0, m0_ready_o}, 32'h1);
    chk("t5_after_rd", m0_rd_o, 32'h55AA55AA);
    chk("t5_after_addr", mem_addr_o, 32'h300);
    tick();
    m0_req_i = 1'b0; mem_ready_i = 1'b0; mem_rd_i = 32'h0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
